delay_wait: RTL and testbench
=============================

DELAY_WAIT -- requirements
Module: delay_wait

Interface
REQ-001 Parameter: TIMEOUT_MS, default 64, wait limit in one_ms ticks, legal range 1..4095.
REQ-002 Localparam: W = $clog2(TIMEOUT_MS+1), width of the elapsed count.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 one_ms  input  1  one-cycle millisecond tick strobe.
REQ-006 req  input  1  one-cycle request from the controller to begin a timed wait.
REQ-007 start  output  1  one-cycle start strobe to the delayed-pulse device.
REQ-008 pulse  input  1  completion pulse returned by the device.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle strobe: pulse received within the limit.
REQ-011 timeout  output  1  one-cycle strobe: limit reached with no pulse.
REQ-012 elapsed  output  W  ms ticks counted in the last wait, held until the next done or timeout.

Function
REQ-013 States: IDLE, ARM, WAIT; all outputs registered.
REQ-014 IDLE with req=1: go to ARM, clear ctr; start=1 on the cycle after req is sampled.
REQ-015 ARM: start=1 for exactly this one cycle; go to WAIT unconditionally; one_ms and pulse are ignored in ARM.
REQ-016 WAIT with pulse=1: done=1 next cycle, elapsed<=ctr, go to IDLE.
REQ-017 WAIT with one_ms=1, pulse=0, ctr==TIMEOUT_MS-1: timeout=1 next cycle, elapsed<=TIMEOUT_MS, go to IDLE.
REQ-018 WAIT with one_ms=1, pulse=0, below the limit: ctr<=ctr+1.
REQ-019 Simultaneous pulse and limit tick in WAIT: pulse wins, giving done=1 and elapsed=TIMEOUT_MS-1.
REQ-020 req while busy=1: ignored, not queued.
REQ-021 pulse in IDLE or ARM: no effect on state, done or elapsed.
REQ-022 done and timeout are never both high; each is high for exactly one cycle per wait.
REQ-023 req on the cycle done or timeout is asserted (state already IDLE): accepted, with start on the next cycle.
REQ-024 ctr never exceeds TIMEOUT_MS-1 and never wraps.

Reset
REQ-025 rst=0 at a clock edge: state=IDLE, ctr=0, start=0, done=0, timeout=0, elapsed=0, busy=0.
REQ-026 Reset mid-wait: the wait is abandoned with no done or timeout; a pulse after reset release is spurious per REQ-021.

Configuration
REQ-027 Macro DELAY_WAIT_SPURIOUS_EN defined: adds output spurious_cnt [7:0], counting pulse=1 cycles that occur in IDLE or ARM.
REQ-028 spurious_cnt saturates at 255, resets to 0, and is not cleared by req.
REQ-029 Macro undefined: no spurious_cnt port and no counter logic; all other behaviour is identical.

Structure
REQ-030 Package delay_wait_pkg holds the state enum (IDLE, ARM, WAIT) and the spurious counter width constant (8).
REQ-031 There is no sub-module; the wait FSM and ms counter are one module.
REQ-032 The bench pairs this block with the existing delayed-pulse model: start drives its start input and its pulse drives this block's pulse input.

Verification
REQ-033 TIMEOUT_MS=64; paired with a D=10 delay model; req at cycle 5 -> start=1 at cycle 6, exactly one done pulse, no timeout, busy low after done.
REQ-034 TIMEOUT_MS=4, pulse held 0, one_ms every 10 cycles after req -> timeout=1 one cycle after the 4th tick, elapsed=4, done never asserted.
REQ-035 TIMEOUT_MS=4, pulse=1 on the same cycle as the 4th tick -> done=1, timeout=0, elapsed=3.
REQ-036 req repeated at cycles 2, 3 and 4 during one wait -> exactly one start pulse; a req on the done cycle -> new start the next cycle.
REQ-037 rst=0 for one cycle during WAIT with elapsed count 2 -> all outputs 0 next cycle, no done or timeout follows; a subsequent pulse in IDLE is ignored.
REQ-038 With DELAY_WAIT_SPURIOUS_EN: 300 pulses applied in IDLE -> spurious_cnt=255; pulses in WAIT are not counted.

Source files
------------

// File: rtl/delay_wait_pkg.sv
// delay_wait_pkg
// Holds the types and constants shared by the timed-wait block and its bench.
//   state_t    : wait FSM encoding (IDLE, ARM, WAIT)
//   SPURIOUS_W : width of the optional spurious-pulse counter
package delay_wait_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int SPURIOUS_W = 8;

endpackage

// File: rtl/delay_wait.sv
// delay_wait
// Starts a delayed-pulse device on request and waits for its completion pulse
// for at most TIMEOUT_MS millisecond ticks. It reports either done (pulse
// seen) or timeout (limit reached). The number of ticks counted is held on
// elapsed until the next wait finishes.
//
// Build option: define DELAY_WAIT_SPURIOUS_EN to add the spurious_cnt port.
// It counts pulse cycles seen while no wait is active (IDLE or ARM) and
// saturates at its maximum value.
//
// Ports
//   clk          : single clock, all logic on the rising edge
//   rst          : synchronous active-low reset
//   one_ms       : one-cycle millisecond tick
//   req          : one-cycle request to begin a timed wait
//   start        : one-cycle start strobe to the delayed-pulse device
//   pulse        : completion pulse from the device
//   busy         : high whenever the FSM is not in IDLE
//   done         : one-cycle strobe, pulse arrived within the limit
//   timeout      : one-cycle strobe, limit reached with no pulse
//   elapsed      : ticks counted in the last wait
//   spurious_cnt : (option) count of pulses outside a wait
module delay_wait
  import delay_wait_pkg::*;
#(
  parameter int TIMEOUT_MS = 64,
  localparam int W = $clog2(TIMEOUT_MS + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         one_ms,
  input  logic         req,
  output logic         start,
  input  logic         pulse,
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic [W-1:0] elapsed
`ifdef DELAY_WAIT_SPURIOUS_EN
  ,
  output logic [SPURIOUS_W-1:0] spurious_cnt
`endif
);

  // The last counter value before the limit tick, and the value reported
  // when the limit is reached.
  localparam logic [W-1:0] LIMIT_M1 = W'(TIMEOUT_MS - 1);
  localparam logic [W-1:0] LIMIT    = W'(TIMEOUT_MS);

  state_t       state, state_n;
  logic [W-1:0] ctr, ctr_n;
  logic         start_n, busy_n, done_n, timeout_n;
  logic [W-1:0] elapsed_n;

  // State register. Every output is a flop loaded from its next-state value,
  // so the device and controller never see combinational glitches.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      ctr     <= '0;
      start   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      elapsed <= '0;
    end else begin
      state   <= state_n;
      ctr     <= ctr_n;
      start   <= start_n;
      busy    <= busy_n;
      done    <= done_n;
      timeout <= timeout_n;
      elapsed <= elapsed_n;
    end
  end

  // Next-state and next-output logic. Strobes default low. elapsed holds its
  // value unless a wait finishes.
  always_comb begin
    state_n   = state;
    ctr_n     = ctr;
    start_n   = 1'b0;
    done_n    = 1'b0;
    timeout_n = 1'b0;
    elapsed_n = elapsed;

    case (state)
      IDLE: begin
        if (req) begin
          state_n = ARM;
          ctr_n   = '0;
          start_n = 1'b1;
        end
      end

      // start is high for the whole ARM cycle. Ticks and pulses are ignored
      // here because the device has not yet seen the start strobe.
      ARM: begin
        state_n = WAIT;
      end

      // A pulse has priority over a tick that arrives in the same cycle. The
      // limit is checked before incrementing, so ctr never reaches TIMEOUT_MS.
      WAIT: begin
        if (pulse) begin
          done_n    = 1'b1;
          elapsed_n = ctr;
          state_n   = IDLE;
        end else if (one_ms) begin
          if (ctr == LIMIT_M1) begin
            timeout_n = 1'b1;
            elapsed_n = LIMIT;
            state_n   = IDLE;
          end else begin
            ctr_n = ctr + W'(1);
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

`ifdef DELAY_WAIT_SPURIOUS_EN
  // Counts pulses that arrive while no wait is active. It saturates at
  // all-ones and is cleared only by reset, not by a new request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      spurious_cnt <= '0;
    end else if (pulse && (state == IDLE || state == ARM) && (spurious_cnt != '1)) begin
      spurious_cnt <= spurious_cnt + 1'b1;
    end
  end
`else
  // Default build: the spurious-pulse counter is not present.
`endif

endmodule

// File: tb/tb_delay_wait.sv
// tb_delay_wait
// Directed bench for delay_wait, with hand-computed expected values.
//   dut_a : TIMEOUT_MS=64. A local delayed-pulse model (D=10) is connected to
//           it: start drives the model, and the model pulse drives pulse.
//   dut_b : TIMEOUT_MS=4. Its ticks and pulses are driven directly by the
//           bench, to exercise the timeout, tie-break and reset cases.
// Define DELAY_WAIT_SPURIOUS_EN to also check the spurious-pulse counter.
`timescale 1ns/1ps
module tb_delay_wait;
  import delay_wait_pkg::*;

  localparam int D = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b0, req_a = 1'b0, one_ms_a = 1'b0;
  logic       start_a, busy_a, done_a, timeout_a, model_pulse;
  logic [6:0] elapsed_a;

  logic       rst_b = 1'b0, req_b = 1'b0, one_ms_b = 1'b0, pulse_b = 1'b0;
  logic       start_b, busy_b, done_b, timeout_b;
  logic [2:0] elapsed_b;
`ifdef DELAY_WAIT_SPURIOUS_EN
  logic [SPURIOUS_W-1:0] spur_a, spur_b;
`endif

  delay_wait #(.TIMEOUT_MS(64)) dut_a (
    .clk(clk), .rst(rst_a), .one_ms(one_ms_a), .req(req_a), .start(start_a),
    .pulse(model_pulse), .busy(busy_a), .done(done_a), .timeout(timeout_a),
    .elapsed(elapsed_a)
`ifdef DELAY_WAIT_SPURIOUS_EN
    , .spurious_cnt(spur_a)
`endif
  );

  delay_wait #(.TIMEOUT_MS(4)) dut_b (
    .clk(clk), .rst(rst_b), .one_ms(one_ms_b), .req(req_b), .start(start_b),
    .pulse(pulse_b), .busy(busy_b), .done(done_b), .timeout(timeout_b),
    .elapsed(elapsed_b)
`ifdef DELAY_WAIT_SPURIOUS_EN
    , .spurious_cnt(spur_b)
`endif
  );

  // Delayed-pulse model: a start seen at a clock edge produces one pulse
  // cycle D edges later.
  int mcnt = 0;
  initial model_pulse = 1'b0;
  always @(posedge clk) begin
    model_pulse <= 1'b0;
    if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) model_pulse <= 1'b1;
    end else if (start_a) begin
      mcnt <= D;
    end
  end

  // Cycle counter and strobe monitors, sampled on the active edge.
  int cyc = 0;
  int start_cnt_a = 0, done_cnt_a = 0, timeout_cnt_a = 0;
  int done_cnt_b = 0, timeout_cnt_b = 0, both_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (start_a)   start_cnt_a   <= start_cnt_a + 1;
    if (done_a)    done_cnt_a    <= done_cnt_a + 1;
    if (timeout_a) timeout_cnt_a <= timeout_cnt_a + 1;
    if (done_b)    done_cnt_b    <= done_cnt_b + 1;
    if (timeout_b) timeout_cnt_b <= timeout_cnt_b + 1;
    if ((done_a && timeout_a) || (done_b && timeout_b)) both_cnt <= both_cnt + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Advance one clock. Outputs are read 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive dut_b's inputs for one cycle.
  task automatic applyStimulus(input logic r, input logic m, input logic p);
    req_b    = r;
    one_ms_b = m;
    pulse_b  = p;
    step();
  endtask

  task automatic waitDoneA(input int budget);
    int n = 0;
    while (!done_a && n < budget) begin
      step();
      n++;
    end
    checkOutput("done_a_seen", done_a, 1);
  endtask

  int s0;

  initial begin
    // Reset both instances.
    repeat (3) step();
    checkOutput("rst_a_strobes", {start_a, busy_a, done_a, timeout_a}, 0);
    checkOutput("rst_a_elapsed", elapsed_a, 0);
    checkOutput("rst_b_strobes", {start_b, busy_b, done_b, timeout_b}, 0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    step();
    step();

    // Basic wait with the D=10 model: req in cycle 5, start in cycle 6.
    req_a = 1'b1;
    step();
    checkOutput("start_a_cycle", cyc, 6);
    checkOutput("start_a", start_a, 1);
    checkOutput("busy_a_armed", busy_a, 1);
    req_a = 1'b0;
    step();
    checkOutput("start_a_one_cycle", start_a, 0);
    waitDoneA(40);
    checkOutput("done_a_cycle", cyc, 18);
    checkOutput("busy_a_after_done", busy_a, 0);
    checkOutput("elapsed_a_zero", elapsed_a, 0);
    step();
    checkOutput("done_a_one_cycle", done_a, 0);
    checkOutput("done_a_count", done_cnt_a, 1);
    checkOutput("timeout_a_count", timeout_cnt_a, 0);

    // A req while busy is ignored. A req on the done cycle is accepted.
    s0 = start_cnt_a;
    req_a = 1'b1;
    step();
    req_a = 1'b0;
    step();
    req_a = 1'b1;
    repeat (3) step();
    req_a = 1'b0;
    step();
    checkOutput("busy_req_single_start", start_cnt_a - s0, 1);
    waitDoneA(40);
    req_a = 1'b1;
    step();
    checkOutput("req_on_done_start", start_a, 1);
    req_a = 1'b0;
    waitDoneA(40);
    step();
    checkOutput("two_starts_total", start_cnt_a - s0, 2);
    checkOutput("done_a_count3", done_cnt_a, 3);

    // Timeout at TIMEOUT_MS=4. A pulse during ARM must be ignored.
    applyStimulus(1, 0, 0);
    checkOutput("start_b", start_b, 1);
    applyStimulus(0, 0, 1);
    checkOutput("arm_pulse_ignored", {done_b, busy_b}, 2'b01);
    for (int k = 1; k <= 4; k++) begin
      repeat (9) applyStimulus(0, 0, 0);
      applyStimulus(0, 1, 0);
      if (k == 3) checkOutput("tick3_no_timeout", {timeout_b, busy_b}, 2'b01);
    end
    checkOutput("timeout_b", timeout_b, 1);
    checkOutput("timeout_elapsed", elapsed_b, 4);
    checkOutput("timeout_no_done", {done_b, busy_b}, 0);
    applyStimulus(0, 0, 0);
    checkOutput("timeout_one_cycle", timeout_b, 0);

    // A pulse on the limit tick wins. A tick during ARM is ignored.
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
    for (int k = 1; k <= 3; k++) begin
      repeat (9) applyStimulus(0, 0, 0);
      applyStimulus(0, 1, 0);
    end
    repeat (9) applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 1);
    checkOutput("tie_done", done_b, 1);
    checkOutput("tie_no_timeout", timeout_b, 0);
    checkOutput("tie_elapsed", elapsed_b, 3);
    applyStimulus(0, 0, 0);
    checkOutput("b_timeout_count", timeout_cnt_b, 1);
    checkOutput("b_done_count", done_cnt_b, 1);

    // Reset mid-wait with ctr=2. The wait is abandoned and a later pulse is
    // spurious.
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 0);
    rst_b = 1'b0;
    applyStimulus(0, 0, 0);
    checkOutput("midrst_strobes", {start_b, busy_b, done_b, timeout_b}, 0);
    checkOutput("midrst_elapsed", elapsed_b, 0);
    rst_b = 1'b1;
    applyStimulus(0, 0, 1);
    checkOutput("idle_pulse_ignored", {done_b, busy_b}, 0);
    repeat (5) applyStimulus(0, 1, 0);
    checkOutput("midrst_no_done", done_cnt_b, 1);
    checkOutput("midrst_no_timeout", timeout_cnt_b, 1);
    checkOutput("midrst_elapsed_held", elapsed_b, 0);
    checkOutput("never_both", both_cnt, 0);

`ifdef DELAY_WAIT_SPURIOUS_EN
    // Spurious-pulse counter: pulses in IDLE and ARM are counted, pulses in
    // WAIT are not. The counter saturates and is not cleared by req.
    rst_b = 1'b0;
    applyStimulus(0, 0, 0);
    checkOutput("spur_reset", spur_b, 0);
    rst_b = 1'b1;
    repeat (5) applyStimulus(0, 0, 1);
    checkOutput("spur_idle5", spur_b, 5);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    checkOutput("spur_wait_not_counted", spur_b, 6);
    checkOutput("spur_wait_done", done_b, 1);
    repeat (300) applyStimulus(0, 0, 1);
    checkOutput("spur_saturate", spur_b, 255);
    applyStimulus(1, 0, 0);
    checkOutput("spur_req_no_clear", spur_b, 255);
    applyStimulus(0, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
